// File: rtl/data_mem_responder.sv
// Responder end of the data-memory request/response interface: services
// loads/stores from an internal word array with configurable wait states.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0]   word_idx;
  logic [31:0]        rd_word;
  logic [31:0]        wdata_sh;
  logic [3:0]         byte_en;
  logic               mem_we;

  // Offset is taken with 32-bit wrap-around, so addresses below the base
  // become huge and fall out of range naturally.
  function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (size == 2'd3) ||
           ((size == 2'd1) && addr[0]) ||
           ((size == 2'd2) && (addr[1:0] != 2'b00)) ||
           ({1'b0, off} >= MEM_BYTES);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] a);
    logic [31:0] sh;
    sh = word >> {a, 3'b000};
    case (size)
      2'd0:    return {24'h0, sh[7:0]};
      2'd1:    return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign word_idx    = IDX_W'((addr_q - BASE_ADDR) >> 2);
  assign rd_word     = mem_q[word_idx];
  assign wdata_sh    = wdata_q << {addr_q[1:0], 3'b000};
  assign byte_en     = lane_mask(size_q, addr_q[1:0]);
  assign mem_we      = (state_q == S_ACCESS) && we_q;

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          size_d  = req_size_i;
          wdata_d = req_wdata_i;
          if (req_error(req_addr_i, req_size_i)) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ACCESS: begin
        rdata_d = we_q ? 32'h0 : load_extract(rd_word, size_q, addr_q[1:0]);
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; a reset aborts ACCESS via state_q.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three builds (1, 0 and 4 wait
// states, one with a non-zero base) driven from a vector table plus sequences.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] req_addr  [3];
  logic [1:0]  req_size  [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_w1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
    .req_we_i(req_we[0]), .req_size_i(req_size[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]), .busy_o(busy[0]));

  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_w0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
    .req_we_i(req_we[1]), .req_size_i(req_size[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]), .busy_o(busy[1]));

  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(4), .BASE_ADDR(32'h8000_0000)) u_w4 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_addr_i(req_addr[2]),
    .req_we_i(req_we[2]), .req_size_i(req_size[2]), .req_wdata_i(req_wdata[2]),
    .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_rdata_o(rsp_rdata[2]),
    .rsp_err_o(rsp_err[2]), .busy_o(busy[2]));

  typedef struct {
    int          d;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 33;
  vec_t vt [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns response fields and the cycle in
  // which rsp_valid first rose, counted from the request handshake cycle.
  task automatic xact(input int d, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_addr[d] = addr; req_wdata[d] = wdata;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = addr ^ 32'h4;
    req_wdata[d] = ~wdata;
    req_we[d]    = ~we;
    lat = 1;
    while (!rsp_valid[d] && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    //        d we size addr           wdata          exp_rdata      err lat
    vt[0]  = '{0, 1, 2'd2, 32'h10,       32'hDEADBEEF, 32'h0,        0, 3};
    vt[1]  = '{0, 0, 2'd2, 32'h10,       32'h0,        32'hDEADBEEF, 0, 3};
    vt[2]  = '{0, 1, 2'd0, 32'h12,       32'h55,       32'h0,        0, 3};
    vt[3]  = '{0, 0, 2'd2, 32'h10,       32'h0,        32'hDE55BEEF, 0, 3};
    vt[4]  = '{0, 1, 2'd1, 32'h10,       32'h1234,     32'h0,        0, 3};
    vt[5]  = '{0, 0, 2'd2, 32'h10,       32'h0,        32'hDE551234, 0, 3};
    vt[6]  = '{0, 0, 2'd0, 32'h13,       32'h0,        32'h000000DE, 0, 3};
    vt[7]  = '{0, 0, 2'd1, 32'h12,       32'h0,        32'h0000DE55, 0, 3};
    vt[8]  = '{0, 0, 2'd1, 32'h11,       32'h0,        32'h0,        1, 1};
    vt[9]  = '{0, 0, 2'd2, 32'h16,       32'h0,        32'h0,        1, 1};
    vt[10] = '{0, 0, 2'd3, 32'h0,        32'h0,        32'h0,        1, 1};
    vt[11] = '{0, 1, 2'd2, 32'h1000,     32'hFFFFFFFF, 32'h0,        1, 1};
    vt[12] = '{0, 1, 2'd1, 32'h13,       32'hFFFF,     32'h0,        1, 1};
    vt[13] = '{0, 0, 2'd2, 32'h10,       32'h0,        32'hDE551234, 0, 3};
    vt[14] = '{0, 1, 2'd0, 32'h11,       32'hFFFFFF77, 32'h0,        0, 3};
    vt[15] = '{0, 0, 2'd2, 32'h10,       32'h0,        32'hDE557734, 0, 3};
    vt[16] = '{0, 0, 2'd0, 32'h11,       32'h0,        32'h00000077, 0, 3};
    vt[17] = '{0, 1, 2'd1, 32'h12,       32'hAAAA5678, 32'h0,        0, 3};
    vt[18] = '{0, 0, 2'd2, 32'h10,       32'h0,        32'h56787734, 0, 3};
    vt[19] = '{0, 0, 2'd1, 32'h10,       32'h0,        32'h00007734, 0, 3};
    vt[20] = '{0, 0, 2'd0, 32'h12,       32'h0,        32'h00000078, 0, 3};
    vt[21] = '{1, 1, 2'd2, 32'h4,        32'hA5A5A5A5, 32'h0,        0, 2};
    vt[22] = '{1, 1, 2'd2, 32'h3C,       32'h0F0F0F0F, 32'h0,        0, 2};
    vt[23] = '{1, 0, 2'd2, 32'h4,        32'h0,        32'hA5A5A5A5, 0, 2};
    vt[24] = '{1, 0, 2'd2, 32'h3C,       32'h0,        32'h0F0F0F0F, 0, 2};
    vt[25] = '{1, 0, 2'd2, 32'h40,       32'h0,        32'h0,        1, 1};
    vt[26] = '{2, 1, 2'd2, 32'h80000000, 32'h13579BDF, 32'h0,        0, 6};
    vt[27] = '{2, 1, 2'd2, 32'h80000004, 32'h2468ACE0, 32'h0,        0, 6};
    vt[28] = '{2, 0, 2'd2, 32'h80000000, 32'h0,        32'h13579BDF, 0, 6};
    vt[29] = '{2, 0, 2'd2, 32'h7FFFFFFC, 32'h0,        32'h0,        1, 1};
    vt[30] = '{2, 0, 2'd2, 32'h80000040, 32'h0,        32'h0,        1, 1};
    vt[31] = '{2, 0, 2'd0, 32'h80000005, 32'h0,        32'h000000AC, 0, 6};
    vt[32] = '{2, 0, 2'd2, 32'h00000000, 32'h0,        32'h0,        1, 1};

    req_valid = '0; req_we = '0; rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k] = '0; req_size[k] = '0; req_wdata[k] = '0;
    end
    rst = 1'b1;

    // Reset state of every build.
    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d req_ready", k), 32'(req_ready[k]), 32'd1);
      check($sformatf("rst%0d rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
      check($sformatf("rst%0d rdata", k),     rsp_rdata[k],       32'd0);
      check($sformatf("rst%0d err", k),       32'(rsp_err[k]),    32'd0);
      check($sformatf("rst%0d busy", k),      32'(busy[k]),       32'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      xact(vt[i].d, vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata, rd, er, lat);
      check($sformatf("v%0d rdata", i),   rd,          vt[i].exp_rdata);
      check($sformatf("v%0d err", i),     32'(er),     32'(vt[i].exp_err));
      check($sformatf("v%0d latency", i), 32'(lat),    32'(vt[i].exp_lat));
      check($sformatf("v%0d clear vld/err", i),
            32'({rsp_valid[vt[i].d], rsp_err[vt[i].d]}), 32'd0);
      check($sformatf("v%0d clear rdata", i), rsp_rdata[vt[i].d], 32'd0);
    end

    // Backpressure with a second request already waiting on the input.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2; req_addr[0] = 32'h10;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    lat = 1;
    while (!rsp_valid[0] && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check("bp latency", 32'(lat), 32'd3);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd1; req_addr[0] = 32'h12;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp%0d rdata", c),     rsp_rdata[0],       32'h56787734);
      check($sformatf("bp%0d err", c),       32'(rsp_err[0]),    32'd0);
      check($sformatf("bp%0d req_ready", c), 32'(req_ready[0]),  32'd0);
      check($sformatf("bp%0d busy", c),      32'(busy[0]),       32'd1);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    check("bp release req_ready", 32'(req_ready[0]), 32'd1);
    check("bp release busy",      32'(busy[0]),      32'd0);
    check("bp release rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("bp release rdata",     rsp_rdata[0],      32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("b2b accepted busy",      32'(busy[0]),      32'd1);
    check("b2b accepted req_ready", 32'(req_ready[0]), 32'd0);
    lat = 1;
    while (!rsp_valid[0] && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check("b2b latency", 32'(lat), 32'd3);
    check("b2b rdata",   rsp_rdata[0], 32'h00005678);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;

    // Reset while a store sits in WAIT: the store must be dropped.
    xact(0, 1'b1, 2'd2, 32'h20, 32'h11111111, rd, er, lat);
    check("pre-rst store err", 32'(er), 32'd0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd2;
    req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("mid-wait busy", 32'(busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst req_ready", 32'(req_ready[0]), 32'd1);
    check("async rst busy",      32'(busy[0]),      32'd0);
    check("async rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("async rst rdata",     rsp_rdata[0],      32'd0);
    check("async rst err",       32'(rsp_err[0]),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid[0]) seen++;
      @(posedge clk); #1;
    end
    check("no rsp after rst", 32'(seen), 32'd0);
    xact(0, 1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat);
    check("post-rst load rdata",   rd,       32'h11111111);
    check("post-rst load err",     32'(er),  32'd0);
    check("post-rst load latency", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (slave) end of the core's data-memory request/response interface. The memory stage issues load/store requests; this block services them from an internal word array.
- It applies configurable wait states, handles byte-lane steering, and flags bad requests.
- It replaces the zero-latency data RAM behind the memory stage, so multi-cycle memory latency can be modelled and tested.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two.
- WAIT_CYCLES, 1: extra wait-state cycles per valid access; 0 is legal.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_rdata_o  out  32  load data, right-aligned, zero-extended; 0 for stores and errors.
- rsp_err_o  out  1  request rejected (misaligned, illegal size, or out of range).
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; req_ready_o = 1; rsp_valid_o = 0; rsp_rdata_o = 0; rsp_err_o = 0; busy_o = 0; wait counter = 0.
  - Memory array contents are not reset.
- States: IDLE, WAIT, ACCESS, RESP. req_ready_o = 1 only in IDLE; it does not depend combinationally on req_valid_i.
- IDLE:
  - On req_valid_i & req_ready_o, latch addr, we, size and wdata.
  - Evaluate the error check. On error, go to RESP with err = 1 and rdata = 0.
  - Otherwise go to WAIT if WAIT_CYCLES > 0, else go to ACCESS.
- Error check, true if any of:
  - size == 3;
  - size == 1 and addr[0] != 0;
  - size == 2 and addr[1:0] != 0;
  - (addr - BASE_ADDR) >= DEPTH_WORDS*4, using unsigned 32-bit wrap-around subtraction.
  - A rejected store never modifies memory.
- WAIT: counter loads WAIT_CYCLES-1 on entry, decrements each cycle, and moves to ACCESS after the cycle in which it equals 0. The block stays in WAIT for exactly WAIT_CYCLES cycles.
- ACCESS (exactly one cycle), word index = (addr - BASE_ADDR) >> 2:
  - Store: byte lanes written = byte: 1 lane at addr[1:0]; half: lanes addr[1]*2 and addr[1]*2+1; word: all 4 lanes. wdata is shifted left by 8*addr[1:0]. Unselected lanes are unchanged.
  - Load: read the word, shift right by 8*addr[1:0], mask to the access size, zero-extend.
  - Register the result into rsp_rdata_o; rsp_err_o = 0. Go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o stay stable until rsp_valid_o & rsp_ready_i, then go to IDLE.
  - rsp_valid_o, rsp_rdata_o and rsp_err_o all clear on leaving RESP.
  - A new request can be accepted no earlier than the cycle after the response handshake.
- Latency, for a request handshake in cycle N:
  - valid request: rsp_valid_o first high in cycle N+2+WAIT_CYCLES;
  - error: rsp_valid_o high in cycle N+1.
- Throughput: one outstanding request, no pipelining.
- Inputs are ignored outside IDLE, and request fields may change freely after acceptance.
- Reset mid-operation: abort immediately to IDLE and drop any pending response.
  - A store already past its ACCESS edge stays committed.
  - A store still in WAIT or ACCESS (before the edge) is not performed.
- Loads from never-written words return X in simulation; the bench preloads or writes first.

Test Plan:
- WAIT_CYCLES=1, BASE=0: store word 0xDEADBEEF @0x10 (handshake cycle N) → rsp_valid in N+3 with err=0, rdata=0; then load word @0x10 → rdata=0xDEADBEEF, rsp_valid 3 cycles after handshake.
- Byte and half lanes: after the word above, store byte 0x55 @0x12 → load word gives 0xDE55BEEF; store half 0x1234 @0x10 → 0xDE551234; load byte @0x13 → 0x000000DE; load half @0x12 → 0x0000DE55.
- Errors: load half @0x11, load word @0x16, size=3 @0x0, and store word @DEPTH_WORDS*4 each → err=1, rdata=0, rsp_valid in N+1; the word @0x10 is unchanged afterwards.
- Backpressure: hold rsp_ready_i=0 for 5 cycles → rsp_valid, rdata and err stable, req_ready_o=0, busy_o=1; release → IDLE next cycle and a back-to-back request is accepted there.
- WAIT_CYCLES=0 and WAIT_CYCLES=4 builds: rsp_valid at exactly N+2 and N+6 respectively; BASE_ADDR=0x8000_0000: an access @0x7FFF_FFFC → err=1, an access @0x8000_0000 → word 0.
- Assert rst_i during the WAIT of a store word 0xCAFEF00D @0x20 (memory held 0x11111111) → all outputs at their reset values asynchronously, no response afterwards, and a later load @0x20 returns 0x11111111.
